// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared Johnson counter types, FSM encoding and pattern helpers
package johnson_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } jc_state_e;

  // Helpers work on patterns up to 32 bits wide; idx field covers 2*32 states.
  localparam int JMAX_W = 32;

  typedef struct packed {
    logic       legal;
    logic [5:0] idx;
  } jdec_t;

  function automatic logic [31:0] width_mask(input int w);
    logic [31:0] m;
    if (w >= JMAX_W) m = 32'hFFFF_FFFF;
    else             m = (32'd1 << w) - 32'd1;
    return m;
  endfunction

  function automatic logic [31:0] johnson_next(input logic [31:0] cur, input int w);
    logic [31:0] m;
    m = width_mask(w);
    return ((cur << 1) | {31'd0, ~cur[w-1]}) & m;
  endfunction

  function automatic jdec_t johnson_decode_f(input logic [31:0] pat, input int w);
    jdec_t       d;
    logic [31:0] m;
    logic [31:0] p;
    d = '0;
    m = width_mask(w);
    p = pat & m;
    // MSB clear: ones fill from the LSB; MSB set: zeros fill from the LSB.
    for (int k = 0; k < JMAX_W; k++) begin
      if (k < w) begin
        if (!p[w-1] && (p == ((32'd1 << k) - 32'd1))) begin
          d.legal = 1'b1;
          d.idx   = 6'(k);
        end
        if (p[w-1] && (p == (~((32'd1 << k) - 32'd1) & m))) begin
          d.legal = 1'b1;
          d.idx   = 6'(w + k);
        end
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - combinational Johnson pattern to {idx, legal} decoder
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] cin,
  output logic [IW-1:0]    idx,
  output logic             legal
);

  logic [31:0] w_pat;
  jdec_t       w_dec;

  always_comb begin
    w_pat            = '0;
    w_pat[WIDTH-1:0] = cin;
    w_dec            = johnson_decode_f(w_pat, WIDTH);
  end

  assign legal = w_dec.legal;
  assign idx   = w_dec.legal ? w_dec.idx[IW-1:0] : '0;

endmodule

// File: rtl/johnson_count_checker.sv
// rtl/johnson_count_checker.sv - Johnson counter monitor: decode, lock FSM, error and wrap tracking
module johnson_count_checker
  import johnson_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int LOCK_CNT = 2,
  parameter  int ERR_W    = 8,
  localparam int IW       = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] cin,
  output logic [IW-1:0]    idx,
  output logic             legal,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  localparam int          SW       = $clog2(LOCK_CNT + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(2 * WIDTH - 1);

  logic [IW-1:0]    w_dec_idx;
  logic             w_dec_legal;
  logic [IW-1:0]    w_prev_succ;
  logic             w_is_succ;
  logic [SW-1:0]    w_streak_inc;

  jc_state_e        r_state, w_state_nxt;
  logic [SW-1:0]    r_streak, w_streak_nxt;
  logic [IW-1:0]    r_prev, w_prev_nxt;
  logic             w_err_nxt, w_wrap_nxt;

  logic [IW-1:0]    r_idx;
  logic             r_legal;
  logic             r_err;
  logic             r_wrap;
  logic [ERR_W-1:0] r_err_count;

  johnson_decode #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_decode (
    .cin   (cin),
    .idx   (w_dec_idx),
    .legal (w_dec_legal)
  );

  assign w_prev_succ  = (r_prev == LAST_IDX) ? '0 : r_prev + IW'(1);
  assign w_is_succ    = w_dec_legal && (w_dec_idx == w_prev_succ);
  assign w_streak_inc = r_streak + SW'(1);

  // Streak counts in-order legal samples, so LOCK_CNT successor steps give LOCK_CNT+1.
  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_prev_nxt   = w_dec_legal ? w_dec_idx : r_prev;
    w_err_nxt    = 1'b0;
    w_wrap_nxt   = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_dec_legal) begin
          w_state_nxt  = VERIFY;
          w_streak_nxt = SW'(1);
        end
      end
      VERIFY: begin
        if (!w_dec_legal) begin
          w_state_nxt  = HUNT;
          w_streak_nxt = '0;
        end else if (w_is_succ) begin
          w_streak_nxt = w_streak_inc;
          if (int'(w_streak_inc) > LOCK_CNT) w_state_nxt = LOCKED;
        end else begin
          w_streak_nxt = SW'(1);
        end
      end
      LOCKED: begin
        if (!w_dec_legal) begin
          w_err_nxt    = 1'b1;
          w_state_nxt  = HUNT;
          w_streak_nxt = '0;
        end else if (w_is_succ) begin
          w_wrap_nxt = (r_prev == LAST_IDX) && (w_dec_idx == '0);
        end else begin
          w_err_nxt    = 1'b1;
          w_state_nxt  = VERIFY;
          w_streak_nxt = SW'(1);
        end
      end
      default: begin
        w_state_nxt  = HUNT;
        w_streak_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HUNT;
      r_streak    <= '0;
      r_prev      <= '0;
      r_idx       <= '0;
      r_legal     <= 1'b0;
      r_err       <= 1'b0;
      r_wrap      <= 1'b0;
      r_err_count <= '0;
    end else if (en) begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      r_prev   <= w_prev_nxt;
      r_idx    <= w_dec_idx;
      r_legal  <= w_dec_legal;
      r_err    <= w_err_nxt;
      r_wrap   <= w_wrap_nxt;
      if (w_err_nxt && (r_err_count != '1)) r_err_count <= r_err_count + ERR_W'(1);
    end else begin
      r_err  <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign idx       = r_idx;
  assign legal     = r_legal;
  assign locked    = (r_state == LOCKED);
  assign err       = r_err;
  assign wrap      = r_wrap;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_johnson_count_checker.sv
// tb/tb_johnson_count_checker.sv - directed table-driven bench for johnson_count_checker
module tb_johnson_count_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] cin;
  logic [3:0] idx;
  logic       legal;
  logic       locked;
  logic       err;
  logic       wrap;
  logic [7:0] err_count;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic       en;
    logic [7:0] cin;
    int         idx;
    int         legal;
    int         locked;
    int         err;
    int         wrap;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  johnson_count_checker dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cin       (cin),
    .idx       (idx),
    .legal     (legal),
    .locked    (locked),
    .err       (err),
    .wrap      (wrap),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic [7:0] c);
    en  = e;
    cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic e, input logic [7:0] c, input int i, input int lg,
                     input int lk, input int er, input int wr, input int cnt);
    vec_t v;
    v.en = e; v.cin = c; v.idx = i; v.legal = lg; v.locked = lk;
    v.err = er; v.wrap = wr; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input int i, input int lg, input int lk,
                         input int er, input int wr, input int cnt);
    chk({tag, " idx"},       int'(idx),       i);
    chk({tag, " legal"},     int'(legal),     lg);
    chk({tag, " locked"},    int'(locked),    lk);
    chk({tag, " err"},       int'(err),       er);
    chk({tag, " wrap"},      int'(wrap),      wr);
    chk({tag, " err_count"}, int'(err_count), cnt);
  endtask

  initial begin
    logic [7:0] seq [16];
    int         exp_cnt;

    seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    // lock-in from reset: idx 0,1 verify, locks on idx 2
    add(1, 8'h00, 0, 1, 0, 0, 0, 0);
    add(1, 8'h01, 1, 1, 0, 0, 0, 0);
    add(1, 8'h03, 2, 1, 1, 0, 0, 0);
    for (int k = 3; k < 16; k++) add(1, seq[k], k, 1, 1, 0, 0, 0);
    // wrap 15 -> 0, then continue to idx 5
    add(1, 8'h00, 0, 1, 1, 0, 1, 0);
    for (int k = 1; k <= 5; k++) add(1, seq[k], k, 1, 1, 0, 0, 0);
    // counter reset while locked at 5
    add(1, 8'h00, 0, 1, 0, 1, 0, 1);
    add(1, 8'h01, 1, 1, 0, 0, 0, 1);
    add(1, 8'h03, 2, 1, 1, 0, 0, 1);
    // illegal pattern while locked, then legal goes only to VERIFY
    add(1, 8'h24, 0, 0, 0, 1, 0, 2);
    add(1, 8'h07, 3, 1, 0, 0, 0, 2);
    add(1, 8'h0F, 4, 1, 0, 0, 0, 2);
    add(1, 8'h1F, 5, 1, 1, 0, 0, 2);
    // en=0 holds everything while cin moves
    add(0, 8'h00, 5, 1, 1, 0, 0, 2);
    add(0, 8'h55, 5, 1, 1, 0, 0, 2);
    add(0, 8'h3F, 5, 1, 1, 0, 0, 2);
    add(1, 8'h3F, 6, 1, 1, 0, 0, 2);
    // repeated index is a non-successor
    add(1, 8'h3F, 6, 1, 0, 1, 0, 3);
    add(1, 8'h7F, 7, 1, 0, 0, 0, 3);
    add(1, 8'hFF, 8, 1, 1, 0, 0, 3);
    // MSB-set illegal patterns; second one in HUNT is not an error
    add(1, 8'hBF, 0, 0, 0, 1, 0, 4);
    add(1, 8'h81, 0, 0, 0, 0, 0, 4);
    // wrap seen in VERIFY produces no pulse
    add(1, 8'h80, 15, 1, 0, 0, 0, 4);
    add(1, 8'h00, 0, 1, 0, 0, 0, 4);
    add(1, 8'h01, 1, 1, 1, 0, 0, 4);

    reset = 1'b1;
    en    = 1'b1;
    cin   = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].cin);
      chk_all($sformatf("v%0d", i), vecs[i].idx, vecs[i].legal, vecs[i].locked,
              vecs[i].err, vecs[i].wrap, vecs[i].cnt);
    end

    // 256 further lock-breaks bring the total to 260; count pins at 255
    exp_cnt = 4;
    for (int n = 0; n < 256; n++) begin
      step(1, 8'h00);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk($sformatf("sat%0d err", n), int'(err), 1);
      chk($sformatf("sat%0d err_count", n), int'(err_count), exp_cnt);
      step(1, 8'h01);
      step(1, 8'h03);
      chk($sformatf("sat%0d relock", n), int'(locked), 1);
    end
    chk("sat final", int'(err_count), 255);

    // reset wins over en while locked
    reset = 1'b1;
    en    = 1'b1;
    cin   = 8'h07;
    @(posedge clk);
    #1;
    chk_all("reset2", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(1, 8'h01);
    chk_all("post_reset", 1, 1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
